// File: rtl/redmule_tb_pkg.sv
// Shared types and constants for the RedMulE data demux: address decode rules,
// MMIO register addresses and the data returned for unmapped accesses.
package redmule_tb_pkg;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] mask;
  } addr_rule_t;

  localparam logic [31:0] EOC_ADDR       = 32'h8000_0000;
  localparam logic [31:0] PUTC_ADDR      = 32'h8000_0004;
  localparam logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF;

  function automatic logic rule_match(input logic [31:0] addr, input addr_rule_t rule);
    return ((addr & rule.mask) == rule.base);
  endfunction

endpackage

// File: rtl/redmule_mmio_responder.sv
// Local responder for the end-of-computation / putc registers and for
// unmapped accesses; answers every accepted request exactly one cycle later.
module redmule_mmio_responder #(
  parameter logic [31:0] EOC_ADDR  = redmule_tb_pkg::EOC_ADDR,
  parameter logic [31:0] PUTC_ADDR = redmule_tb_pkg::PUTC_ADDR
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        unmapped_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        eoc_o,
  output logic [31:0] eoc_code_o,
  output logic        putc_valid_o,
  output logic [7:0]  putc_char_o
);
  import redmule_tb_pkg::*;

  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_eoc;
  logic [31:0] r_eoc_code;
  logic        r_putc_valid;
  logic [7:0]  r_putc_char;

  logic [31:0] w_rdata;
  logic        w_err;
  logic        w_eoc_wr;
  logic        w_putc_wr;

  // response data and register side effects of the accepted request
  always_comb begin
    w_rdata   = 32'h0000_0000;
    w_err     = 1'b0;
    w_eoc_wr  = 1'b0;
    w_putc_wr = 1'b0;
    if (unmapped_i) begin
      w_rdata = UNMAPPED_RDATA;
      w_err   = 1'b1;
    end else if (we_i) begin
      w_eoc_wr  = req_i & (addr_i == EOC_ADDR);
      w_putc_wr = req_i & (addr_i == PUTC_ADDR);
    end else if (addr_i == EOC_ADDR) begin
      w_rdata = r_eoc_code;
    end else begin
      w_rdata = 32'h0000_0000;
    end
  end

  // response registers plus sticky EOC and one-shot putc strobe
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid     <= 1'b0;
      r_rdata      <= 32'h0000_0000;
      r_err        <= 1'b0;
      r_eoc        <= 1'b0;
      r_eoc_code   <= 32'h0000_0000;
      r_putc_valid <= 1'b0;
      r_putc_char  <= 8'h00;
    end else begin
      r_rvalid     <= req_i;
      r_putc_valid <= w_putc_wr;
      if (req_i) begin
        r_rdata <= w_rdata;
        r_err   <= w_err;
      end else begin
        r_rdata <= 32'h0000_0000;
        r_err   <= 1'b0;
      end
      if (w_eoc_wr) begin
        r_eoc      <= 1'b1;
        r_eoc_code <= wdata_i;
      end
      if (w_putc_wr) begin
        r_putc_char <= wdata_i[7:0];
      end
    end
  end

  assign rvalid_o     = r_rvalid;
  assign rdata_o      = r_rdata;
  assign err_o        = r_err;
  assign eoc_o        = r_eoc;
  assign eoc_code_o   = r_eoc_code;
  assign putc_valid_o = r_putc_valid;
  assign putc_char_o  = r_putc_char;

endmodule

// File: rtl/redmule_data_demux.sv
// Routes a single host data port to N address-decoded targets or the local
// MMIO responder, keeping responses in order by only mixing same-select requests.
module redmule_data_demux #(
  parameter int unsigned                 N_TARGETS = 3,
  parameter int unsigned                 MAX_OUT   = 2,
  parameter logic [N_TARGETS-1:0][31:0]  TGT_BASE  = {32'h1C01_0000, 32'h0000_0000, 32'h1C10_0000},
  parameter logic [N_TARGETS-1:0][31:0]  TGT_MASK  = {32'hFF00_0000, 32'hFF00_0000, 32'hFFF0_0000},
  parameter logic [31:0]                 EOC_ADDR  = redmule_tb_pkg::EOC_ADDR,
  parameter logic [31:0]                 PUTC_ADDR = redmule_tb_pkg::PUTC_ADDR
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_i,
  output logic                        gnt_o,
  input  logic [31:0]                 addr_i,
  input  logic                        we_i,
  input  logic [3:0]                  be_i,
  input  logic [31:0]                 wdata_i,
  output logic [31:0]                 rdata_o,
  output logic                        rvalid_o,
  output logic                        err_o,
  output logic [N_TARGETS-1:0]        tgt_req_o,
  input  logic [N_TARGETS-1:0]        tgt_gnt_i,
  output logic [31:0]                 tgt_addr_o,
  output logic                        tgt_we_o,
  output logic [3:0]                  tgt_be_o,
  output logic [31:0]                 tgt_wdata_o,
  input  logic [N_TARGETS-1:0][31:0]  tgt_rdata_i,
  input  logic [N_TARGETS-1:0]        tgt_rvalid_i,
  output logic                        eoc_o,
  output logic [31:0]                 eoc_code_o,
  output logic                        putc_valid_o,
  output logic [7:0]                  putc_char_o
);
  import redmule_tb_pkg::*;

  // selects 0..N_TARGETS-1 are targets, then MMIO, then UNMAPPED
  localparam int unsigned      SEL_W        = $clog2(N_TARGETS + 2);
  localparam int unsigned      CNT_W        = $clog2(MAX_OUT + 1);
  localparam logic [SEL_W-1:0] SEL_MMIO     = SEL_W'(N_TARGETS);
  localparam logic [SEL_W-1:0] SEL_UNMAPPED = SEL_W'(N_TARGETS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);

  logic [CNT_W-1:0]     r_cnt;
  logic [SEL_W-1:0]     r_cur_sel;

  logic [SEL_W-1:0]     w_dec_sel;
  logic                 w_dec_is_tgt;
  logic                 w_allow;
  logic [N_TARGETS-1:0] w_tgt_req;
  logic                 w_tgt_gnt;
  logic                 w_gnt;
  logic                 w_hs;
  logic                 w_cur_is_tgt;
  logic                 w_tgt_rvalid;
  logic [31:0]          w_tgt_rdata;
  logic                 w_rvalid;
  logic [31:0]          w_rdata;
  logic                 w_err;
  logic                 w_mmio_rvalid;
  logic [31:0]          w_mmio_rdata;
  logic                 w_mmio_err;

  // address decode: MMIO first, then lowest-index matching target
  always_comb begin
    w_dec_sel = SEL_UNMAPPED;
    if ((addr_i == EOC_ADDR) || (addr_i == PUTC_ADDR)) begin
      w_dec_sel = SEL_MMIO;
    end else begin
      for (int t = int'(N_TARGETS) - 1; t >= 0; t--) begin
        w_dec_sel = rule_match(addr_i, '{base: TGT_BASE[t], mask: TGT_MASK[t]}) ? SEL_W'(t) : w_dec_sel;
      end
    end
  end

  assign w_dec_is_tgt = (w_dec_sel < SEL_MMIO);
  assign w_allow      = (r_cnt < CNT_MAX) && ((r_cnt == CNT_ZERO) || (w_dec_sel == r_cur_sel));

  // one-hot target request and combinational grant passthrough
  always_comb begin
    w_tgt_req = {N_TARGETS{1'b0}};
    w_tgt_gnt = 1'b0;
    for (int t = 0; t < int'(N_TARGETS); t++) begin
      w_tgt_req[t] = req_i & w_allow & (w_dec_sel == SEL_W'(t));
      w_tgt_gnt    = w_tgt_gnt | (w_tgt_req[t] & tgt_gnt_i[t]);
    end
    w_gnt = w_dec_is_tgt ? w_tgt_gnt : (req_i & w_allow);
  end

  assign w_hs = req_i & w_gnt;

  // response path: only the currently selected source, only while outstanding
  always_comb begin
    w_tgt_rvalid = 1'b0;
    w_tgt_rdata  = 32'h0000_0000;
    for (int t = 0; t < int'(N_TARGETS); t++) begin
      w_tgt_rvalid = (r_cur_sel == SEL_W'(t)) ? tgt_rvalid_i[t] : w_tgt_rvalid;
      w_tgt_rdata  = (r_cur_sel == SEL_W'(t)) ? tgt_rdata_i[t]  : w_tgt_rdata;
    end
    w_cur_is_tgt = (r_cur_sel < SEL_MMIO);
    if (w_cur_is_tgt) begin
      w_rvalid = w_tgt_rvalid & (r_cnt != CNT_ZERO);
      w_rdata  = w_rvalid ? w_tgt_rdata : 32'h0000_0000;
      w_err    = 1'b0;
    end else begin
      w_rvalid = w_mmio_rvalid & (r_cnt != CNT_ZERO);
      w_rdata  = w_rvalid ? w_mmio_rdata : 32'h0000_0000;
      w_err    = w_rvalid & w_mmio_err;
    end
  end

  // outstanding counter and current select tracking
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt     <= CNT_ZERO;
      r_cur_sel <= {SEL_W{1'b0}};
    end else begin
      if (w_hs) begin
        r_cur_sel <= w_dec_sel;
      end
      case ({w_hs, w_rvalid})
        2'b10:   r_cnt <= r_cnt + CNT_ONE;
        2'b01:   r_cnt <= r_cnt - CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  redmule_mmio_responder #(
    .EOC_ADDR  (EOC_ADDR),
    .PUTC_ADDR (PUTC_ADDR)
  ) u_mmio (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_i        (w_hs & ~w_dec_is_tgt),
    .unmapped_i   (w_dec_sel == SEL_UNMAPPED),
    .addr_i       (addr_i),
    .we_i         (we_i),
    .wdata_i      (wdata_i),
    .rvalid_o     (w_mmio_rvalid),
    .rdata_o      (w_mmio_rdata),
    .err_o        (w_mmio_err),
    .eoc_o        (eoc_o),
    .eoc_code_o   (eoc_code_o),
    .putc_valid_o (putc_valid_o),
    .putc_char_o  (putc_char_o)
  );

  assign gnt_o       = w_gnt;
  assign tgt_req_o   = w_tgt_req;
  assign tgt_addr_o  = addr_i;
  assign tgt_we_o    = we_i;
  assign tgt_be_o    = be_i;
  assign tgt_wdata_o = wdata_i;
  assign rvalid_o    = w_rvalid;
  assign rdata_o     = w_rdata;
  assign err_o       = w_err;

endmodule

// File: tb/tb_redmule_data_demux.sv
// Directed scoreboard bench for redmule_data_demux: stimulus pushes expected
// responses, a negedge monitor pops and compares whenever rvalid_o is high.
module tb_redmule_data_demux;

  localparam logic [31:0] EOC  = 32'h8000_0000;
  localparam logic [31:0] PUTC = 32'h8000_0004;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              req_i;
  logic              gnt_o;
  logic [31:0]       addr_i;
  logic              we_i;
  logic [3:0]        be_i;
  logic [31:0]       wdata_i;
  logic [31:0]       rdata_o;
  logic              rvalid_o;
  logic              err_o;
  logic [2:0]        tgt_req_o;
  logic [2:0]        tgt_gnt_i;
  logic [31:0]       tgt_addr_o;
  logic              tgt_we_o;
  logic [3:0]        tgt_be_o;
  logic [31:0]       tgt_wdata_o;
  logic [2:0][31:0]  tgt_rdata_i;
  logic [2:0]        tgt_rvalid_i;
  logic              eoc_o;
  logic [31:0]       eoc_code_o;
  logic              putc_valid_o;
  logic [7:0]        putc_char_o;

  redmule_data_demux dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .rvalid_o(rvalid_o), .err_o(err_o),
    .tgt_req_o(tgt_req_o), .tgt_gnt_i(tgt_gnt_i), .tgt_addr_o(tgt_addr_o), .tgt_we_o(tgt_we_o),
    .tgt_be_o(tgt_be_o), .tgt_wdata_o(tgt_wdata_o), .tgt_rdata_i(tgt_rdata_i), .tgt_rvalid_i(tgt_rvalid_i),
    .eoc_o(eoc_o), .eoc_code_o(eoc_code_o), .putc_valid_o(putc_valid_o), .putc_char_o(putc_char_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk_i) begin
    rsp_t e;
    if (rvalid_o === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rsp: got rdata %h err %b expected no response", rdata_o, err_o);
      end else begin
        e = exp_q.pop_front();
        if (rdata_o !== e.rdata || err_o !== e.err) begin
          bad++;
          $display("FAIL rsp: got rdata %h err %b expected rdata %h err %b", rdata_o, err_o, e.rdata, e.err);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk_i);
  endtask

  task automatic drive(input logic r, input logic [31:0] a, input logic w, input logic [31:0] d);
    req_i   = r;
    addr_i  = a;
    we_i    = w;
    wdata_i = d;
    be_i    = 4'hF;
  endtask

  task automatic push(input logic [31:0] d, input logic e);
    exp_q.push_back('{rdata: d, err: e});
  endtask

  task automatic check_reset(input string nm);
    check({nm, "_gnt"},    32'(gnt_o),        32'd0);
    check({nm, "_rvalid"}, 32'(rvalid_o),     32'd0);
    check({nm, "_err"},    32'(err_o),        32'd0);
    check({nm, "_rdata"},  rdata_o,           32'd0);
    check({nm, "_tgtreq"}, 32'(tgt_req_o),    32'd0);
    check({nm, "_eoc"},    32'(eoc_o),        32'd0);
    check({nm, "_code"},   eoc_code_o,        32'd0);
    check({nm, "_putcv"},  32'(putc_valid_o), 32'd0);
    check({nm, "_putcc"},  32'(putc_char_o),  32'd0);
  endtask

  task automatic mmio(input string nm, input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [31:0] er, input logic ee);
    drive(1'b1, a, w, d);
    at_neg();
    check({nm, "_gnt"}, 32'(gnt_o), 32'd1);
    push(er, ee);
    cyc();
    drive(1'b0, 32'd0, 1'b0, 32'd0);
    at_neg();
    check({nm, "_lat"}, 32'(rvalid_o), 32'd1);
    cyc();
  endtask

  initial begin
    rst_ni       = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 32'd0);
    tgt_gnt_i    = 3'b111;
    tgt_rvalid_i = 3'b000;
    tgt_rdata_i  = {3{32'd0}};
    repeat (2) at_neg();
    check_reset("rst0");
    cyc();
    rst_ni = 1'b1;
    cyc();

    // EOC / MMIO / unmapped
    mmio("eoc_wr0", EOC, 1'b1, 32'd0, 32'd0, 1'b0);
    check("eoc_set", 32'(eoc_o), 32'd1);
    check("eoc_code0", eoc_code_o, 32'd0);
    mmio("eoc_rd0", EOC, 1'b0, 32'd0, 32'd0, 1'b0);
    mmio("eoc_wr1", EOC, 1'b1, 32'hCAFE_0042, 32'd0, 1'b0);
    check("eoc_sticky", 32'(eoc_o), 32'd1);
    check("eoc_code1", eoc_code_o, 32'hCAFE_0042);
    mmio("eoc_rd1", EOC, 1'b0, 32'd0, 32'hCAFE_0042, 1'b0);
    mmio("putc_rd", PUTC, 1'b0, 32'd0, 32'd0, 1'b0);
    mmio("unm_rd", 32'h4000_0000, 1'b0, 32'd0, 32'hDEAD_BEEF, 1'b1);
    mmio("unm_wr", 32'h4000_0000, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1);
    check("unm_nofx", eoc_code_o, 32'hCAFE_0042);

    // single putc pulse
    drive(1'b1, PUTC, 1'b1, 32'h0000_0041);
    at_neg(); check("putc_gnt", 32'(gnt_o), 32'd1); push(32'd0, 1'b0);
    cyc(); drive(1'b0, 32'd0, 1'b0, 32'd0);
    at_neg(); check("putc_v", 32'(putc_valid_o), 32'd1); check("putc_c", 32'(putc_char_o), 32'h41);
    cyc();
    at_neg(); check("putc_pulse_end", 32'(putc_valid_o), 32'd0);
    cyc();

    // back-to-back putc writes
    drive(1'b1, PUTC, 1'b1, 32'h0000_0042);
    at_neg(); check("b2b_gnt0", 32'(gnt_o), 32'd1); push(32'd0, 1'b0);
    cyc(); drive(1'b1, PUTC, 1'b1, 32'h0000_0043);
    at_neg(); check("b2b_gnt1", 32'(gnt_o), 32'd1); push(32'd0, 1'b0);
    check("b2b_c0", 32'(putc_char_o), 32'h42); check("b2b_rv0", 32'(rvalid_o), 32'd1);
    cyc(); drive(1'b0, 32'd0, 1'b0, 32'd0);
    at_neg(); check("b2b_v1", 32'(putc_valid_o), 32'd1); check("b2b_c1", 32'(putc_char_o), 32'h43);
    check("b2b_rv1", 32'(rvalid_o), 32'd1);
    cyc();

    // target routing, MAX_OUT hold, select switch
    drive(1'b1, 32'h1C10_0000, 1'b0, 32'd0);
    at_neg(); check("t0a_req", 32'(tgt_req_o), 32'd1); check("t0a_gnt", 32'(gnt_o), 32'd1);
    push(32'h1111_0000, 1'b0);
    cyc(); drive(1'b1, 32'h1C10_0004, 1'b0, 32'd0);
    at_neg(); check("t0b_gnt", 32'(gnt_o), 32'd1); push(32'h1111_0004, 1'b0);
    cyc(); drive(1'b1, 32'h1C10_0008, 1'b0, 32'd0);
    at_neg(); check("maxout_gnt", 32'(gnt_o), 32'd0); check("maxout_req", 32'(tgt_req_o), 32'd0);
    cyc(); tgt_rvalid_i = 3'b001; tgt_rdata_i[0] = 32'h1111_0000;
    at_neg(); check("maxout_rsp_gnt", 32'(gnt_o), 32'd0);
    cyc(); tgt_rvalid_i = 3'b000;
    at_neg(); check("t0c_gnt", 32'(gnt_o), 32'd1); check("t0c_req", 32'(tgt_req_o), 32'd1);
    push(32'h1111_0008, 1'b0);
    cyc(); drive(1'b1, 32'h0000_1000, 1'b0, 32'd0);
    tgt_rvalid_i = 3'b001; tgt_rdata_i[0] = 32'h1111_0004;
    at_neg(); check("sw_gnt0", 32'(gnt_o), 32'd0);
    cyc(); tgt_rdata_i[0] = 32'h1111_0008;
    at_neg(); check("sw_gnt1", 32'(gnt_o), 32'd0); check("sw_req1", 32'(tgt_req_o), 32'd0);
    cyc(); tgt_rvalid_i = 3'b000; tgt_gnt_i = 3'b101;
    at_neg(); check("t1_req", 32'(tgt_req_o), 32'd2); check("t1_nognt", 32'(gnt_o), 32'd0);
    cyc(); tgt_gnt_i = 3'b111;
    at_neg(); check("t1_gnt", 32'(gnt_o), 32'd1); push(32'h2222_1000, 1'b0);
    cyc(); drive(1'b0, 32'd0, 1'b0, 32'd0);
    tgt_rvalid_i = 3'b011; tgt_rdata_i[1] = 32'h2222_1000; tgt_rdata_i[0] = 32'hBAD0_BAD0;
    at_neg(); check("t1_err", 32'(err_o), 32'd0);
    cyc(); tgt_rvalid_i = 3'b010;
    at_neg(); check("stray_idle", 32'(rvalid_o), 32'd0);
    cyc(); tgt_rvalid_i = 3'b000;

    // reset with two outstanding target reads
    drive(1'b1, 32'h1C10_0000, 1'b0, 32'd0);
    at_neg(); check("r_gnt0", 32'(gnt_o), 32'd1);
    cyc();
    at_neg(); check("r_gnt1", 32'(gnt_o), 32'd1);
    cyc(); drive(1'b0, 32'd0, 1'b0, 32'd0); rst_ni = 1'b0; tgt_rvalid_i = 3'b001;
    tgt_rdata_i[0] = 32'h5555_5555;
    at_neg(); check_reset("rst_mid");
    cyc(); rst_ni = 1'b1;
    at_neg(); check("late_rsp", 32'(rvalid_o), 32'd0);
    cyc(); tgt_rvalid_i = 3'b000; drive(1'b1, 32'h1C10_0010, 1'b0, 32'd0);
    at_neg(); check("post_rst_gnt", 32'(gnt_o), 32'd1); push(32'h3333_0010, 1'b0);
    cyc(); drive(1'b0, 32'd0, 1'b0, 32'd0); tgt_rvalid_i = 3'b001; tgt_rdata_i[0] = 32'h3333_0010;
    at_neg();
    cyc(); tgt_rvalid_i = 3'b000;
    at_neg(); check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/redmule_data_demux.md
REDMULE_DATA_DEMUX -- requirements
Module: redmule_data_demux

Interface
REQ-001 SHALL have parameter N_TARGETS, default 3: number of downstream memory/peripheral targets, 1..8.
REQ-002 SHALL have parameter MAX_OUT, default 2: maximum outstanding host transactions, 1..8.
REQ-003 SHALL have parameter TGT_BASE, default {32'h1C01_0000, 32'h0000_0000, 32'h1C10_0000}: per-target address match value.
REQ-004 SHALL have parameter TGT_MASK, default {32'hFF00_0000, 32'hFF00_0000, 32'hFFF0_0000}: per-target address match mask.
REQ-005 SHALL have parameter EOC_ADDR, default 32'h8000_0000: end-of-computation register address.
REQ-006 SHALL have parameter PUTC_ADDR, default 32'h8000_0004: character output register address.
REQ-007 SHALL have one clock and asynchronous active-low reset: clk_i input 1 (rising edge), rst_ni input 1 (async, active low).
REQ-008 SHALL have host request ports: req_i in 1, gnt_o out 1, addr_i in 32, we_i in 1 (1 = write), be_i in 4, wdata_i in 32.
REQ-009 SHALL have host response ports: rdata_o out 32, rvalid_o out 1, err_o out 1 (valid with rvalid_o).
REQ-010 SHALL have per-target request ports: tgt_req_o out N_TARGETS, tgt_gnt_i in N_TARGETS, tgt_addr_o out 32, tgt_we_o out 1, tgt_be_o out 4, tgt_wdata_o out 32; address and data are broadcast to all targets.
REQ-011 SHALL have per-target response ports: tgt_rdata_i in N_TARGETS x 32, tgt_rvalid_i in N_TARGETS.
REQ-012 SHALL have status ports: eoc_o out 1 (sticky), eoc_code_o out 32, putc_valid_o out 1, putc_char_o out 8.

Function
REQ-013 Decode SHALL use this priority: addr_i == EOC_ADDR or PUTC_ADDR selects internal MMIO; otherwise the lowest t with (addr_i & TGT_MASK[t]) == TGT_BASE[t]; otherwise UNMAPPED.
REQ-014 A request SHALL be allowed only when cnt < MAX_OUT and (cnt == 0 or decoded select == cur_sel); otherwise all tgt_req_o are 0 and gnt_o is 0.
REQ-015 An allowed target request SHALL drive tgt_req_o one-hot and gnt_o = tgt_gnt_i[sel] combinationally, with zero added latency.
REQ-016 An allowed MMIO or UNMAPPED request SHALL be granted in the same cycle.
REQ-017 The handshake req_i & gnt_o SHALL load cur_sel and increment cnt; a routed response SHALL decrement cnt; both in the same cycle SHALL leave cnt unchanged.
REQ-018 rvalid_o/rdata_o SHALL come from tgt_rvalid_i[cur_sel]/tgt_rdata_i[cur_sel] when cur_sel is a target; err_o SHALL be 0.
REQ-019 A tgt_rvalid_i from a non-selected target, or any response while cnt == 0, SHALL be ignored.
REQ-020 The MMIO/UNMAPPED responder SHALL assert rvalid_o exactly 1 cycle after the handshake and SHALL sustain back-to-back handshakes.
REQ-021 MMIO response data: a read of EOC_ADDR returns eoc_code_o; a read of PUTC_ADDR returns 0; writes return 0; err_o = 0.
REQ-022 UNMAPPED response: rdata_o = 32'hDEAD_BEEF, err_o = 1, no side effects.
REQ-023 A write to EOC_ADDR SHALL set eoc_o = 1 and eoc_code_o = wdata_i on the following cycle; a later write updates the code and eoc_o stays 1.
REQ-024 A write to PUTC_ADDR SHALL pulse putc_valid_o for exactly 1 cycle, 1 cycle after the handshake, with putc_char_o = wdata_i[7:0].
REQ-025 cnt SHALL be $clog2(MAX_OUT+1) bits wide and SHALL never exceed MAX_OUT or go below 0.

Reset
REQ-026 On rst_ni low, asynchronously: cnt = 0, cur_sel = 0, responder idle; gnt_o, rvalid_o, err_o, eoc_o, putc_valid_o and tgt_req_o are 0; eoc_code_o = 0; putc_char_o = 0; rdata_o = 0 when not valid.
REQ-027 Reset during an outstanding transaction SHALL drop the transaction; target responses arriving after reset SHALL be ignored.

Structure
REQ-028 A shared package redmule_tb_pkg SHALL hold the addr_rule_t struct (base, mask) and the EOC_ADDR/PUTC_ADDR/UNMAPPED_RDATA constants.
REQ-029 The MMIO/UNMAPPED responder SHALL be the sub-module redmule_mmio_responder.

Verification
REQ-030 Write 0 to 32'h8000_0000 -> rvalid_o 1 cycle later, err_o = 0, eoc_o = 1 and eoc_code_o = 0 thereafter; a read of the same address returns 0.
REQ-031 Write 32'h41 to 32'h8000_0004 -> putc_valid_o high for 1 cycle with putc_char_o = 8'h41.
REQ-032 Two reads to target 0 (8'h1C region) with tgt_gnt_i held high, then a read to 32'h0000_1000 -> third request not granted until cnt == 0, then routed to target 1.
REQ-033 MAX_OUT = 2, target 0 withholds rvalid -> third same-target request held (gnt_o = 0) until one response returns.
REQ-034 Read of 32'h4000_0000 -> rvalid_o 1 cycle later, rdata_o = 32'hDEAD_BEEF, err_o = 1.
REQ-035 rst_ni pulsed low with cnt = 2 -> cnt = 0, outputs at reset values, and a late tgt_rvalid_i does not produce rvalid_o.
